gravity_sweep_scheduler: RTL and testbench

Sequencer that owns the per-frame schedule of the shared gravity micro-step datapath (one pair/axis velocity update per accepted step).
- On each accepted frame tick: issues a one-cycle position-commit strobe.
- Then walks every ordered (P,Q) planet pair × axis, presenting each step through a valid/ready handshake gated by VGA blanking.
- Adds run/pause, single-frame stepping, a frame counter and sticky overrun detection.
- Sits between the VGA timing generator and the gravity datapath.

---
 rtl/gravity_sweep_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_gravity_sweep_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gravity_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : gravity_sweep_scheduler
// Description : Per-frame sequencer for the shared gravity micro-step
//               datapath. Each accepted frame tick produces one position-
//               commit strobe. The block then walks every ordered (P,Q)
//               planet pair x axis as a valid/ready step stream, and steps
//               are only presented while VGA blanking is high. It also
//               provides run/pause, single-frame stepping, a frame counter
//               and sticky overrun detection.
// Ports       : clk, rst_n (async, active-low)
//               frame_tick, blanking, run, single_step, overrun_clr (in)
//               step_ready (in) / step_valid, p_idx, q_idx, axis (out)
//               pos_commit, sweep_busy, overrun, frame_count[7:0] (out)
// Build macro : SCHED_OVERRUN_RESTART_EN - when defined, a frame tick that
//               arrives while busy restarts the sweep instead of being
//               dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module gravity_sweep_scheduler #(
    parameter int N_PLANETS        = 3,
    parameter int SWEEPS_PER_FRAME = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       blanking,
    input  logic       run,
    input  logic       single_step,
    input  logic       overrun_clr,
    input  logic       step_ready,
    output logic       step_valid,
    output logic [1:0] p_idx,
    output logic [1:0] q_idx,
    output logic       axis,
    output logic       pos_commit,
    output logic       sweep_busy,
    output logic       overrun,
    output logic [7:0] frame_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] COMMIT = 2'd1;
    localparam logic [1:0] SWEEP  = 2'd2;

    localparam logic [2:0] C_NP         = 3'(N_PLANETS);
    localparam logic [1:0] C_LAST_SWEEP = 2'(SWEEPS_PER_FRAME - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] p_q, p_d;
    logic [1:0] q_q, q_d;
    logic       axis_q, axis_d;
    logic [1:0] sweep_q, sweep_d;
    logic       pending_q, pending_d;
    logic       ss_q, ss_d;
    logic       overrun_q, overrun_d;
    logic [7:0] fcnt_q, fcnt_d;

    logic       w_busy;
    logic       w_tick_ok;
    logic       w_xfer;
    logic [2:0] w_q_next;
    logic [2:0] w_p_next;

    assign w_busy     = (state_q != IDLE);
    // A tick is usable when free-running or when a single frame is armed.
    assign w_tick_ok  = frame_tick & (run | pending_q);
    assign step_valid = (state_q == SWEEP) & blanking;
    assign w_xfer     = step_valid & step_ready;

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        q_d       = q_q;
        axis_d    = axis_q;
        sweep_d   = sweep_q;
        overrun_d = overrun_q;
        fcnt_d    = fcnt_q;
        ss_d      = single_step;
        w_q_next  = 3'd0;
        w_p_next  = 3'd0;

        // Pending is only meaningful while paused; a repeat edge is a no-op.
        if (run) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q | (single_step & ~ss_q);
        end

        case (state_q)
            IDLE: begin
                if (w_tick_ok) begin
                    state_d   = COMMIT;
                    pending_d = 1'b0;
                    fcnt_d    = fcnt_q + 8'd1;
                end
            end
            COMMIT: begin
                p_d     = 2'd0;
                q_d     = 2'd1;
                axis_d  = 1'b0;
                sweep_d = 2'd0;
                state_d = SWEEP;
            end
            SWEEP: begin
                if (w_xfer) begin
                    if (!axis_q) begin
                        axis_d = 1'b1;
                    end else begin
                        axis_d = 1'b0;
                        // Next attractor skips the planet being updated.
                        w_q_next = {1'b0, q_q} + 3'd1;
                        if (w_q_next == {1'b0, p_q}) begin
                            w_q_next = {1'b0, q_q} + 3'd2;
                        end
                        if (w_q_next < C_NP) begin
                            q_d = w_q_next[1:0];
                        end else begin
                            w_p_next = {1'b0, p_q} + 3'd1;
                            if (w_p_next < C_NP) begin
                                // p is now >= 1, so the lowest q != p is 0.
                                p_d = w_p_next[1:0];
                                q_d = 2'd0;
                            end else if (sweep_q == C_LAST_SWEEP) begin
                                state_d = IDLE;
                                p_d     = 2'd0;
                                q_d     = 2'd0;
                                sweep_d = 2'd0;
                            end else begin
                                p_d     = 2'd0;
                                q_d     = 2'd1;
                                sweep_d = sweep_q + 2'd1;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Set beats clear when both happen together.
        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (w_busy && frame_tick) begin
            overrun_d = 1'b1;
`ifdef SCHED_OVERRUN_RESTART_EN
            if (w_tick_ok) begin
                state_d   = COMMIT;
                pending_d = 1'b0;
                fcnt_d    = fcnt_q + 8'd1;
                p_d       = 2'd0;
                q_d       = 2'd0;
                axis_d    = 1'b0;
                sweep_d   = 2'd0;
            end
`else
            // The tick is dropped and the running sweep is left untouched.
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            p_q       <= 2'd0;
            q_q       <= 2'd0;
            axis_q    <= 1'b0;
            sweep_q   <= 2'd0;
            pending_q <= 1'b0;
            ss_q      <= 1'b0;
            overrun_q <= 1'b0;
            fcnt_q    <= 8'd0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            q_q       <= q_d;
            axis_q    <= axis_d;
            sweep_q   <= sweep_d;
            pending_q <= pending_d;
            ss_q      <= ss_d;
            overrun_q <= overrun_d;
            fcnt_q    <= fcnt_d;
        end
    end

    assign p_idx       = p_q;
    assign q_idx       = q_q;
    assign axis        = axis_q;
    assign pos_commit  = (state_q == COMMIT);
    assign sweep_busy  = w_busy;
    assign overrun     = overrun_q;
    assign frame_count = fcnt_q;

endmodule
`default_nettype wire

// File: tb/tb_gravity_sweep_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_gravity_sweep_scheduler
// Description : Directed self-checking bench for gravity_sweep_scheduler
//               (N_PLANETS=3, SWEEPS_PER_FRAME=1, default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gravity_sweep_scheduler;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic       blanking;
    logic       run;
    logic       single_step;
    logic       overrun_clr;
    logic       step_ready;
    logic       step_valid;
    logic [1:0] p_idx;
    logic [1:0] q_idx;
    logic       axis;
    logic       pos_commit;
    logic       sweep_busy;
    logic       overrun;
    logic [7:0] frame_count;

    int n_tests;
    int n_fail;

    // Hand-written step order for 3 planets: {p[1:0], q[1:0], axis}.
    logic [4:0] exp_tbl [12];

    gravity_sweep_scheduler #(
        .N_PLANETS        (3),
        .SWEEPS_PER_FRAME (1)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .blanking    (blanking),
        .run         (run),
        .single_step (single_step),
        .overrun_clr (overrun_clr),
        .step_ready  (step_ready),
        .step_valid  (step_valid),
        .p_idx       (p_idx),
        .q_idx       (q_idx),
        .axis        (axis),
        .pos_commit  (pos_commit),
        .sweep_busy  (sweep_busy),
        .overrun     (overrun),
        .frame_count (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {step_valid, p_idx, q_idx, axis, pos_commit, sweep_busy, overrun, frame_count}, 32'd0);
    endtask

    // Pulse frame_tick for one cycle; then expect the commit strobe.
    task automatic start_frame(input logic [7:0] exp_fc);
        @(negedge clk);
        frame_tick = 1'b1;
        #1;
        @(negedge clk);
        frame_tick = 1'b0;
        #1;
        check("commit_strobe", {31'd0, pos_commit}, 32'd1);
        check("commit_busy", {31'd0, sweep_busy}, 32'd1);
        check("commit_fc", {24'd0, frame_count}, {24'd0, exp_fc});
    endtask

    // Collect transfers and compare them to the expected order.
    // blank_mode 1 toggles blanking every 3 cycles; stall_k stalls ready for
    // 5 cycles while step stall_k is presented; stop_k ends collection early.
    task automatic collect(input int blank_mode, input int stall_k, input int stop_k);
        int k;
        int stalls;
        k      = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 200 && k < stop_k; cyc++) begin
            @(negedge clk);
            blanking   = (blank_mode == 1) ? ((cyc / 3) % 2 == 0) : 1'b1;
            step_ready = 1'b1;
            if (k == stall_k && stalls < 5) begin
                step_ready = 1'b0;
                stalls++;
            end
            #1;
            if (blank_mode == 1) begin
                check("valid_gated", {31'd0, step_valid}, {31'd0, blanking});
            end
            if (!step_ready) begin
                check("stall_valid", {31'd0, step_valid}, 32'd1);
                check("stall_hold", {27'd0, p_idx, q_idx, axis}, {27'd0, exp_tbl[k]});
            end
            if (step_valid && step_ready) begin
                check($sformatf("step%0d", k), {27'd0, p_idx, q_idx, axis}, {27'd0, exp_tbl[k]});
                k++;
            end
        end
        check("xfer_count", k, stop_k);
        if (stop_k == 12) begin
            @(negedge clk);
            #1;
            check("end_busy", {31'd0, sweep_busy}, 32'd0);
            check("end_valid", {31'd0, step_valid}, 32'd0);
            check("end_idx", {27'd0, p_idx, q_idx, axis}, 32'd0);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_tbl[0]  = {2'd0, 2'd1, 1'b0};
        exp_tbl[1]  = {2'd0, 2'd1, 1'b1};
        exp_tbl[2]  = {2'd0, 2'd2, 1'b0};
        exp_tbl[3]  = {2'd0, 2'd2, 1'b1};
        exp_tbl[4]  = {2'd1, 2'd0, 1'b0};
        exp_tbl[5]  = {2'd1, 2'd0, 1'b1};
        exp_tbl[6]  = {2'd1, 2'd2, 1'b0};
        exp_tbl[7]  = {2'd1, 2'd2, 1'b1};
        exp_tbl[8]  = {2'd2, 2'd0, 1'b0};
        exp_tbl[9]  = {2'd2, 2'd0, 1'b1};
        exp_tbl[10] = {2'd2, 2'd1, 1'b0};
        exp_tbl[11] = {2'd2, 2'd1, 1'b1};

        rst_n       = 1'b0;
        frame_tick  = 1'b0;
        blanking    = 1'b0;
        run         = 1'b0;
        single_step = 1'b0;
        overrun_clr = 1'b0;
        step_ready  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset_outputs");
        rst_n = 1'b1;

        // Basic free-running frame.
        run        = 1'b1;
        blanking   = 1'b1;
        step_ready = 1'b1;
        start_frame(8'd1);
        collect(0, 99, 12);
        check("fc_after_frame1", {24'd0, frame_count}, 32'd1);

        // Blanking toggling every 3 cycles.
        start_frame(8'd2);
        collect(1, 99, 12);

        // Ready stall while step (1,0,Y) is presented.
        start_frame(8'd3);
        collect(0, 5, 12);

        // Tick while busy -> overrun, dropped tick.
        @(negedge clk);
        step_ready = 1'b0;
        blanking   = 1'b1;
        start_frame(8'd4);
        @(negedge clk);
        step_ready = 1'b0;
        frame_tick = 1'b1;
        #1;
        @(negedge clk);
        frame_tick = 1'b0;
        #1;
        check("overrun_set", {31'd0, overrun}, 32'd1);
        check("overrun_fc_held", {24'd0, frame_count}, 32'd4);
        check("overrun_no_commit", {31'd0, pos_commit}, 32'd0);
        frame_tick  = 1'b1;
        overrun_clr = 1'b1;
        #1;
        @(negedge clk);
        frame_tick  = 1'b0;
        overrun_clr = 1'b0;
        #1;
        check("overrun_set_wins", {31'd0, overrun}, 32'd1);
        check("overrun_no_commit2", {31'd0, pos_commit}, 32'd0);
        overrun_clr = 1'b1;
        #1;
        @(negedge clk);
        overrun_clr = 1'b0;
        #1;
        check("overrun_cleared", {31'd0, overrun}, 32'd0);
        check("overrun_fc_still", {24'd0, frame_count}, 32'd4);
        collect(0, 99, 12);

        // Paused: ticks ignored until a single-step edge arms one frame.
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            frame_tick = 1'b1;
            #1;
            @(negedge clk);
            frame_tick = 1'b0;
            #1;
            check("paused_no_commit", {31'd0, pos_commit}, 32'd0);
            check("paused_idle", {31'd0, sweep_busy}, 32'd0);
        end
        @(negedge clk);
        single_step = 1'b1;
        #1;
        @(negedge clk);
        single_step = 1'b0;
        start_frame(8'd5);
        collect(0, 99, 12);
        @(negedge clk);
        frame_tick = 1'b1;
        #1;
        @(negedge clk);
        frame_tick = 1'b0;
        #1;
        check("step_consumed_commit", {31'd0, pos_commit}, 32'd0);
        check("step_consumed_fc", {24'd0, frame_count}, 32'd5);

        // Asynchronous reset in the middle of a sweep.
        run = 1'b1;
        start_frame(8'd6);
        collect(0, 99, 7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midsweep_reset");
        @(negedge clk);
        rst_n = 1'b1;
        start_frame(8'd1);
        collect(0, 99, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
